// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multicycle MIPS core: opcode and
//               funct encodings, controller state and ALU operation enums,
//               and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, JR, TRAP
    } state_t;

    typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return SUB;
            FN_AND:  return AND;
            FN_OR:   return OR;
            FN_SLT:  return SLT;
            default: return ADD;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mc_regfile
// Description : 32 x 32 register file, two asynchronous read ports, one
//               synchronous write port, asynchronous active-low clear.
//               r0 always reads zero and ignores writes.
// Ports       : clock, reset_n      - clock / async active-low clear
//               ra1, ra2 -> rd1, rd2 - combinational read ports
//               we, wa, wd          - write enable, address, data
// Revision    : 1.0 - initial release
// ============================================================================
module mc_regfile
    import mc_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule
`default_nettype wire

// File: rtl/mc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mc_datapath
// Description : Multicycle MIPS-subset core with a single unified memory port
//               (req/ready handshake). Controller FSM, ALU and next-PC logic
//               are inline; the register file is a sub-module.
// Ports       : clock, reset_n  - clock / async active-low reset
//               mem_req/we/addr/wdata, mem_ready/rdata - memory handshake
//               pc     - architectural PC
//               retire - one-cycle pulse in each instruction's final state
//               trap   - sticky illegal-instruction / misalignment flag
// Revision    : 1.0 - initial release
// ============================================================================
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          EN_JAL   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);

    state_t      state, next_state;
    logic [31:0] ir, mdr, a, b, aluout;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, ea, alu_y, rf_a, rf_b, rf_wd;
    logic [4:0]  rf_wa;
    logic        rf_we;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign simm  = sext16(ir[15:0]);
    assign ea    = a + simm;

    mc_regfile u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .ra1     (rs),
        .ra2     (rt),
        .rd1     (rf_a),
        .rd2     (rf_b),
        .we      (rf_we),
        .wa      (rf_wa),
        .wd      (rf_wd)
    );

    always_comb begin
        alu_y = a + b;
        case (funct_to_alu(funct))
            SUB:     alu_y = a - b;
            AND:     alu_y = a & b;
            OR:      alu_y = a | b;
            SLT:     alu_y = {31'd0, ($signed(a) < $signed(b))};
            default: alu_y = a + b;
        endcase
    end

    // Address mux: instruction fetch uses PC, every data access uses ALUOut.
    assign mem_addr  = ((state == IDLE) || (state == FETCH)) ? pc : aluout;
    assign mem_wdata = b;
    assign trap      = (state == TRAP);

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        retire     = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = rt;
        rf_wd      = aluout;
        case (state)
            IDLE:   next_state = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: next_state = EXEC;
                            FN_JR: begin
                                if (EN_JAL) next_state = JR;
                                else        next_state = TRAP;
                            end
                            default: next_state = TRAP;
                        endcase
                    end
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    OP_JAL: begin
                        if (EN_JAL) next_state = JUMP;
                        else        next_state = TRAP;
                    end
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR: begin
                if (ea[1:0] != 2'b00) next_state = TRAP;
                else if (op == OP_LW) next_state = MEMRD;
                else                  next_state = MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                rf_we      = 1'b1;
                rf_wd      = mdr;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            EXEC:   next_state = ALUWB;
            ALUWB: begin
                rf_we      = 1'b1;
                rf_wa      = rd;
                retire     = 1'b1;
                next_state = FETCH;
            end
            ADDIEX: next_state = ADDIWB;
            ADDIWB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                retire     = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                // pc already holds the incremented return address here
                if (op == OP_JAL) begin
                    rf_we = 1'b1;
                    rf_wa = 5'd31;
                    rf_wd = pc;
                end
                retire     = 1'b1;
                next_state = FETCH;
            end
            JR: begin
                if (a[1:0] != 2'b00) begin
                    next_state = TRAP;
                end else begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            TRAP:    next_state = TRAP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            state <= next_state;
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                DECODE: begin
                    a      <= rf_a;
                    b      <= rf_b;
                    aluout <= pc + {simm[29:0], 2'b00};
                end
                MEMADR: aluout <= ea;
                MEMRD:  if (mem_ready) mdr <= mem_rdata;
                EXEC:   aluout <= alu_y;
                ADDIEX: aluout <= ea;
                BRANCH: if (a == b) pc <= aluout;
                JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                JR:     if (a[1:0] == 2'b00) pc <= a;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_datapath
// Description : Self-checking bench for mc_datapath. A wait-state memory
//               model serves the main core; a second core (wrapped reset PC,
//               jal disabled) runs from a tiny zero-wait ROM. Expected retire
//               latencies and post-retire PCs are queued per program and
//               popped as retire pulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_datapath;
    import mc_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic        req2, we2, ready2, retire2, trap2;
    logic [31:0] addr2, wdata2, rdata2, pc2;
    logic [31:0] rom2 [64];

    always #5 clock = ~clock;

    mc_datapath dut (
        .clock(clock), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .pc(pc), .retire(retire), .trap(trap)
    );

    mc_datapath #(.RESET_PC(32'hFFFF_FFFC), .EN_JAL(1'b0)) dut2 (
        .clock(clock), .reset_n(reset_n), .mem_req(req2), .mem_we(we2),
        .mem_addr(addr2), .mem_wdata(wdata2), .mem_ready(ready2),
        .mem_rdata(rdata2), .pc(pc2), .retire(retire2), .trap(trap2)
    );

    assign ready2 = 1'b1;
    assign rdata2 = rom2[addr2[7:2]];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    // ---------------- memory model ----------------
    logic [31:0] mem [256];
    int fetch_waits = 0;
    int data_waits  = 0;
    int wcnt        = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    initial mem_ready = 1'b0;
    initial mem_rdata = '0;

    always @(posedge clock) begin
        int need;
        #2;
        if (mem_req) begin
            need = (mem_addr == pc) ? fetch_waits : data_waits;
            if (wcnt == 0) begin
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
            end else begin
                chk("hold_addr", mem_addr, cap_addr);
                chk("hold_we", {31'd0, mem_we}, {31'd0, cap_we});
                chk("hold_wdata", mem_wdata, cap_wdata);
            end
            if (wcnt >= need) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } exp_t;
    exp_t        sb[$];
    int          cyc = 0;
    int          last_ret = 0;
    bit          pend = 0;
    logic [31:0] pend_pc;
    int          n_ret2 = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        exp_t e;
        if (pend) begin
            chk("pc_after_retire", pc, pend_pc);
            pend = 0;
        end
        if (retire) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", {31'd0, retire}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("retire_latency", cyc - last_ret, e.cyc);
                pend    = 1;
                pend_pc = e.pc;
            end
            last_ret = cyc;
        end
        if (retire2) begin
            n_ret2++;
            chk("wrap_pc", pc2, 32'h0);
        end
    end

    task automatic expect_ret(input int cycles, input logic [31:0] pc_after);
        exp_t e;
        e.cyc = cycles;
        e.pc  = pc_after;
        sb.push_back(e);
    endtask

    task automatic assert_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        sb.delete();
        pend = 0;
        n_ret2 = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic release_reset(input int fw, input int dw);
        fetch_waits = fw;
        data_waits  = dw;
        @(posedge clock);
        #1 reset_n = 1'b1;
        last_ret = cyc;
        @(negedge clock);
        chk("idle_no_req", {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        chk("first_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("first_fetch_addr", mem_addr, 32'h0);
    endtask

    task automatic drain_and_trap(input logic [31:0] frozen_pc);
        int n = 0;
        while ((sb.size() != 0 || pend) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("drain_in_budget", {31'd0, (n < 400)}, 32'd1);
        repeat (10) @(negedge clock);
        chk("trap_set", {31'd0, trap}, 32'd1);
        chk("trap_pc_frozen", pc, frozen_pc);
        chk("trap_no_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) rom2[i] = 32'h0;
        rom2[63] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);  // at 0xFFFF_FFFC
        rom2[0]  = enc_j(OP_JAL, 26'h10);              // traps: jal disabled

        // ---- P1: straight-line ALU, zero wait states ----
        assert_reset();
        mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
        mem[3] = enc_r(5'd2, 5'd1, 5'd4, FN_SLT);
        mem[4] = enc_r(5'd1, 5'd2, 5'd5, FN_SUB);
        mem[5] = enc_r(5'd1, 5'd2, 5'd6, FN_AND);
        mem[6] = enc_r(5'd1, 5'd2, 5'd7, FN_OR);
        mem[7] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7);
        mem[8] = 32'hFC00_0000;
        for (int i = 1; i <= 8; i++) expect_ret(4, 32'(4 * i));
        release_reset(0, 0);
        drain_and_trap(32'd36);
        chk("r1", dut.u_regfile.regs[1], 32'd5);
        chk("r2", dut.u_regfile.regs[2], -32'sd3);
        chk("r3_add", dut.u_regfile.regs[3], 32'd2);
        chk("r4_slt", dut.u_regfile.regs[4], 32'd1);
        chk("r5_sub", dut.u_regfile.regs[5], 32'd8);
        chk("r6_and", dut.u_regfile.regs[6], 32'd5);
        chk("r7_or", dut.u_regfile.regs[7], 32'hFFFF_FFFD);
        chk("r0_zero", dut.u_regfile.regs[0], 32'd0);
        chk("wrap_trap2", {31'd0, trap2}, 32'd1);
        chk("wrap_pc2", pc2, 32'd4);
        chk("wrap_ret2", n_ret2, 32'd1);
        chk("wrap_r1", dut2.u_regfile.regs[1], 32'd1);

        // ---- P2: loads/stores with two data wait states, misaligned lw ----
        assert_reset();
        mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(OP_SW, 5'd0, 5'd1, 16'h40);
        mem[2] = enc_i(OP_LW, 5'd0, 5'd5, 16'h40);
        mem[3] = enc_i(OP_LW, 5'd0, 5'd6, 16'd2);
        expect_ret(4, 32'd4);
        expect_ret(6, 32'd8);
        expect_ret(7, 32'd12);
        release_reset(0, 2);
        drain_and_trap(32'd16);
        chk("mem_0x40", mem[16], 32'd5);
        chk("r5_lw", dut.u_regfile.regs[5], 32'd5);
        chk("r6_untouched", dut.u_regfile.regs[6], 32'd0);

        // ---- P3: branch / jal / jr / j with one fetch wait state ----
        assert_reset();
        mem[0]  = enc_i(OP_BEQ, 5'd1, 5'd1, 16'd2);
        mem[3]  = enc_j(OP_JAL, 26'h40);
        mem[64] = enc_r(5'd31, 5'd0, 5'd0, FN_JR);
        mem[4]  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
        mem[5]  = enc_i(OP_BEQ, 5'd0, 5'd1, 16'd5);
        mem[6]  = enc_j(OP_J, 26'h10);
        mem[16] = 32'hFFFF_FFFF;
        expect_ret(4, 32'd12);
        expect_ret(4, 32'h100);
        expect_ret(4, 32'd16);
        expect_ret(5, 32'd20);
        expect_ret(4, 32'd24);
        expect_ret(4, 32'h40);
        release_reset(1, 0);
        drain_and_trap(32'h44);
        chk("r31_link", dut.u_regfile.regs[31], 32'd16);

        // ---- P4: reset asserted during a store wait ----
        assert_reset();
        mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd9);
        mem[1] = enc_i(OP_SW, 5'd0, 5'd1, 16'h40);
        expect_ret(4, 32'd4);
        release_reset(0, 5);
        n = 0;
        while (!mem_we && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("store_started", {31'd0, mem_we}, 32'd1);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, mem_req}, 32'd0);
        chk("async_we_drop", {31'd0, mem_we}, 32'd0);
        @(negedge clock);
        chk("store_not_done", mem[16], 32'd0);
        chk("reset_pc", pc, 32'h0);
        sb.delete();
        pend = 0;
        release_reset(0, 0);
        reset_n = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mc_datapath.md
# mc_datapath

Multicycle successor to the single-cycle MIPS datapath: one 32-bit core (datapath, controller FSM, register file) sharing a single instruction/data memory port with a req/ready handshake, so memory may insert wait states. It takes 3–5 cycles per instruction, plus memory waits. It sits between the top level and a unified memory, and reports retirement and traps for the testbench.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- EN_JAL, 1'b1: enables `jal` and `jr`; when 0, both opcodes trap as illegal.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  32  byte address: PC in IDLE/FETCH, otherwise ALUOut.
- mem_wdata  out  32  store data (register B).
- mem_ready  in  1  access completes in the cycle where mem_req && mem_ready.
- mem_rdata  in  32  read data, valid in the completing cycle.
- pc  out  32  architectural PC register.
- retire  out  1  one-cycle pulse in the final state of each instruction.
- trap  out  1  sticky; set on illegal opcode/funct or misaligned address.

## Operation
- Internal registers: PC, IR, MDR, A, B, ALUOut, and a 32×32 register file.
  - r0 reads 0; writes to r0 are dropped.
- Supported instructions:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), jr 001000.
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010, jal 000011.
- Immediates are sign-extended 16→32. All arithmetic is mod 2^32; overflow is ignored.
- FSM states and transitions:
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: mem_req=1, mem_addr=PC. Wait while !mem_ready. On completion: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(simm<<2). Dispatch on op/funct.
  - MEMADR: ALUOut<=A+simm. Go to MEMRD (lw) or MEMWR (sw); go to TRAP if A+simm is not word-aligned.
  - MEMRD: read access at ALUOut; on completion MDR<=mem_rdata, go to MEMWB.
  - MEMWB: rf[rt]<=MDR, retire, go to FETCH.
  - MEMWR: mem_we=1 until completion; then retire, go to FETCH.
  - EXEC: ALUOut<=A op B, then go to ALUWB, which does rf[rd]<=ALUOut, retire, go to FETCH.
  - ADDIEX: ALUOut<=A+simm, then go to ADDIWB, which does rf[rt]<=ALUOut, retire, go to FETCH.
  - BRANCH: if A==B then PC<=ALUOut. Retire, go to FETCH.
  - JUMP: PC<={PC[31:28],IR[25:0],2'b00}. For jal, also rf[31]<=PC (the already-incremented PC). Retire, go to FETCH.
  - JR: PC<=A, retire; go to TRAP instead if A[1:0]!=0.
  - TRAP: trap=1, mem_req=0. Terminal until reset; PC is frozen.
- Unknown opcode or funct in DECODE goes to TRAP, with no register or PC update.
- Trapping instructions do not pulse retire.

## Timing
- Reset values: state IDLE, pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0, retire=0, trap=0. All register-file entries and internal registers are 0.
- Reset asserted mid-access drops mem_req and mem_we immediately (asynchronously). An in-flight store must not be counted as complete.
- Cycle counts with zero wait states: beq/j/jal/jr 3, R-type/addi/sw 4, lw 5. Each memory wait cycle adds one cycle.
- First fetch request appears in the 2nd cycle after reset release.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and !mem_ready.
  - mem_req deasserts in the cycle after completion, except FETCH→DECODE, where it deasserts naturally.
  - mem_ready while mem_req=0 is ignored.
- A register-file write in a writeback state is visible to the DECODE read of the next instruction. No bypassing is needed.
- PC wrap-around: PC+4 at 32'hFFFF_FFFC yields 0.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct localparams;
  - the `state_t` enum (IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, JR, TRAP);
  - the `alu_op_t` enum (ADD, SUB, AND, OR, SLT).
- Sub-module `mc_regfile`: 2 asynchronous read ports, 1 synchronous write port, asynchronous active-low clear, r0 hardwired to 0.
- ALU and next-PC muxing stay inline in `mc_datapath`.

## Test plan
- Straight-line ALU, zero wait states: `addi r1,r0,5`; `addi r2,r0,-3`; `add r3,r1,r2`; `slt r4,r2,r1` → r3=2, r4=1, four retire pulses 4 cycles apart, pc=16.
- Memory with 2 wait states: `sw r1,8(r0)`; `lw r5,8(r0)` → mem[8]=5, r5=5. mem_addr/mem_we/mem_wdata held stable through the waits. sw takes 6 cycles, lw 7.
- Branch and jump: `beq r1,r1,+2` from pc=0 → pc=12 (3 cycles). `jal 0x40` at pc=12 → pc=0x100, r31=16. `jr r31` → pc=16.
- Traps:
  - `lw r6,2(r0)` → trap=1, no retire, mem_req stays 0, pc=addr+4 frozen.
  - Opcode 111111 → trap.
  - EN_JAL=0 with a `jal` → trap.
- r0 and wrap: `addi r0,r0,7` leaves r0=0. With RESET_PC=32'hFFFF_FFFC, the first fetch completes with pc=0.
- Reset mid-store: assert reset_n=0 during a MEMWR wait → mem_req=0 and mem_we=0 in the same cycle; after release, pc=RESET_PC and the first fetch is in cycle 2.
